// File: rtl/decoder_2x4_reg.sv
// Registered 2-to-4 one-hot decoder with enable and output polarity; 1-cycle latency, no backpressure (en=0 holds).
// Optional per-line saturating hit counters under `DEC_HIT_CNT_EN (default build drives them to 0).
module decoder_2x4_reg #(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             A,
  input  logic             B,
  output logic             I0,
  output logic             I1,
  output logic             I2,
  output logic             I3,
  output logic             valid,
  output logic [CNT_W-1:0] hit_cnt0,
  output logic [CNT_W-1:0] hit_cnt1,
  output logic [CNT_W-1:0] hit_cnt2,
  output logic [CNT_W-1:0] hit_cnt3
);

  localparam logic [3:0] LINES_OFF = ACTIVE_LOW ? 4'b1111 : 4'b0000;

  logic [1:0] sel;
  logic [3:0] lines;

  assign sel = {A, B};

  // XOR with the idle pattern gives one-hot in either polarity.
  always_ff @(posedge clk) begin
    if (rst) begin
      lines <= LINES_OFF;
      valid <= 1'b0;
    end else if (en) begin
      lines <= LINES_OFF ^ (4'b0001 << sel);
      valid <= 1'b1;
    end
  end

  assign {I3, I2, I1, I0} = lines;

`ifdef DEC_HIT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (sel == 2'(i) && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_ONE;
      end
    end
  end

  assign hit_cnt0 = cnt[0];
  assign hit_cnt1 = cnt[1];
  assign hit_cnt2 = cnt[2];
  assign hit_cnt3 = cnt[3];
`else
  assign hit_cnt0 = '0;
  assign hit_cnt1 = '0;
  assign hit_cnt2 = '0;
  assign hit_cnt3 = '0;
`endif

endmodule

// File: tb/tb_decoder_2x4_reg.sv
// Bench for decoder_2x4_reg: active-high/16-bit-counter and active-low/2-bit-counter instances share stimulus.
module tb_decoder_2x4_reg;

  logic clk = 1'b0;
  logic rst, en, a, b;

  logic        h_i0, h_i1, h_i2, h_i3, h_vld;
  logic [15:0] h_c0, h_c1, h_c2, h_c3;
  logic        l_i0, l_i1, l_i2, l_i3, l_vld;
  logic [1:0]  l_c0, l_c1, l_c2, l_c3;

  always #5 clk = ~clk;

  decoder_2x4_reg #(.ACTIVE_LOW(1'b0), .CNT_W(16)) u_hi (
    .clk(clk), .rst(rst), .en(en), .A(a), .B(b),
    .I0(h_i0), .I1(h_i1), .I2(h_i2), .I3(h_i3), .valid(h_vld),
    .hit_cnt0(h_c0), .hit_cnt1(h_c1), .hit_cnt2(h_c2), .hit_cnt3(h_c3)
  );

  decoder_2x4_reg #(.ACTIVE_LOW(1'b1), .CNT_W(2)) u_lo (
    .clk(clk), .rst(rst), .en(en), .A(a), .B(b),
    .I0(l_i0), .I1(l_i1), .I2(l_i2), .I3(l_i3), .valid(l_vld),
    .hit_cnt0(l_c0), .hit_cnt1(l_c1), .hit_cnt2(l_c2), .hit_cnt3(l_c3)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] ab;
    logic [3:0] lines;   // expected {I3..I0} in active-high sense
    logic       vld;
  } vec_t;

  typedef struct {
    logic [3:0]       lines;
    logic             vld;
    logic [3:0][15:0] c16;
    logic [3:0][1:0]  c2;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Counter reference: saturating per-line counts of enabled decodes.
  int m16 [4];
  int m2  [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] ab,
                      input logic [3:0] lines, input logic vld);
    exp_t x;
    exp_t got;
    rst = r; en = e; {a, b} = ab;
    if (r) begin
      for (int i = 0; i < 4; i++) begin m16[i] = 0; m2[i] = 0; end
    end else if (e) begin
      if (m16[ab] < 65535) m16[ab]++;
      if (m2[ab] < 3) m2[ab]++;
    end
    x.lines = lines;
    x.vld   = vld;
    for (int i = 0; i < 4; i++) begin
`ifdef DEC_HIT_CNT_EN
      x.c16[i] = 16'(m16[i]);
      x.c2[i]  = 2'(m2[i]);
`else
      x.c16[i] = '0;
      x.c2[i]  = '0;
`endif
    end
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++; n_miss++;
      $display("FAIL scoreboard: queue empty, got 0 entries, expected 1");
    end else begin
      got = exp_q.pop_front();
      check("hi_lines", {28'd0, h_i3, h_i2, h_i1, h_i0}, {28'd0, got.lines});
      check("hi_valid", {31'd0, h_vld}, {31'd0, got.vld});
      check("lo_lines", {28'd0, l_i3, l_i2, l_i1, l_i0}, {28'd0, ~got.lines});
      check("lo_valid", {31'd0, l_vld}, {31'd0, got.vld});
      check("hi_cnt", {h_c3, h_c2, h_c1, h_c0}, 32'(64'(got.c16)));
      check("hi_cnt_hi", {16'd0, h_c3, h_c2}, {16'd0, got.c16[3], got.c16[2]});
      check("lo_cnt", {24'd0, l_c3, l_c2, l_c1, l_c0}, {24'd0, got.c2});
    end
  endtask

  vec_t vecs[14];

  initial begin
    rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0;
    for (int i = 0; i < 4; i++) begin m16[i] = 0; m2[i] = 0; end

    vecs[0]  = '{1'b1, 1'b0, 2'b00, 4'b0000, 1'b0};  // reset, two cycles
    vecs[1]  = '{1'b1, 1'b0, 2'b00, 4'b0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'b00, 4'b0001, 1'b1};  // exhaustive decode
    vecs[3]  = '{1'b0, 1'b1, 2'b01, 4'b0010, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 2'b10, 4'b0100, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 2'b11, 4'b1000, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 2'b10, 4'b0100, 1'b1};  // enable hold
    vecs[7]  = '{1'b0, 1'b0, 2'b01, 4'b0100, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 2'b01, 4'b0100, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 2'b01, 4'b0100, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 2'b01, 4'b0010, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 2'b11, 4'b0000, 1'b0};  // rst beats en
    vecs[12] = '{1'b0, 1'b1, 2'b11, 4'b1000, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 2'b00, 4'b1000, 1'b1};

    for (int i = 0; i < 14; i++)
      step(vecs[i].rst, vecs[i].en, vecs[i].ab, vecs[i].lines, vecs[i].vld);

    // Counter saturation: line 0 five times in a row, outputs unchanged after the first.
    step(1'b1, 1'b0, 2'b00, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'b00, 4'b0001, 1'b1);
`ifdef DEC_HIT_CNT_EN
    check("lo_cnt0_sat", {30'd0, l_c0}, 32'd3);
    check("hi_cnt0_five", {16'd0, h_c0}, 32'd5);
`else
    check("lo_cnt0_off", {30'd0, l_c0}, 32'd0);
    check("hi_cnt0_off", {16'd0, h_c0}, 32'd0);
`endif

    // Disabled cycles must not count, then a mid-stream reset clears everything.
    step(1'b0, 1'b0, 2'b11, 4'b0001, 1'b1);
    step(1'b0, 1'b1, 2'b11, 4'b1000, 1'b1);
    step(1'b1, 1'b0, 2'b10, 4'b0000, 1'b0);
    step(1'b0, 1'b0, 2'b10, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 2'b10, 4'b0100, 1'b1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/decoder_2x4_reg.md
Name: decoder_2x4_reg

Overview:
Registered 2-to-4 line decoder with one-hot outputs. It converts a 2-bit select (A = MSB, B = LSB) into four one-hot lines I0..I3, one clock of latency. It is used as an address or channel-select decoder in gate-level and RTL datapaths where a glitch-free, registered select is needed. It adds an enable, a configurable output polarity and an output-valid strobe.

Parameters:
ACTIVE_LOW, 0, 1 = outputs are active-low (selected line 0, others 1); 0 = active-high.
CNT_W, 16, width of each per-output hit counter (optional feature only).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  decode enable; A/B are sampled only when en=1
A  input  1  select MSB
B  input  1  select LSB
I0  output  1  asserted when registered {A,B}=2'b00
I1  output  1  asserted when registered {A,B}=2'b01
I2  output  1  asserted when registered {A,B}=2'b10
I3  output  1  asserted when registered {A,B}=2'b11
valid  output  1  high when I0..I3 hold a decoded value
hit_cnt0..hit_cnt3  output  CNT_W  per-line decode counts (optional feature; 0 when compiled out)

Behaviour:
- All state updates on the rising clk edge. rst has priority over en.
- Reset: valid=0. I0..I3 all deasserted: 0 when ACTIVE_LOW=0, 1 when ACTIVE_LOW=1. Hit counters = 0.
- en=1, rst=0: next edge latches {A,B}. Exactly one of I0..I3 asserted: index = 2*A + B. valid=1. Latency is 1 cycle from sampled inputs to outputs.
- en=0, rst=0: outputs and valid hold their previous values. Inputs are ignored.
- One-hot invariant: after reset, no more than one line is asserted in any cycle. Exactly one is asserted whenever valid=1.
- Outputs come directly from flops, with no combinational path from A/B/en to I0..I3. This gives glitch-free outputs.
- Polarity: ACTIVE_LOW applies to I0..I3 only. valid is always active-high.
- Reset mid-operation: a rst asserted in any cycle clears outputs at that edge, regardless of en or A/B.
- Same select on consecutive enabled cycles: output is unchanged and the counter still increments (see optional feature).
- X/Z on A/B with en=1 is out of specification. No X-propagation handling is required.

Optional Feature:
Macro DEC_HIT_CNT_EN.
- Defined: on each enabled decode, the counter hit_cntN for the selected line N increments by 1. The counter saturates at 2^CNT_W-1 and does not wrap. rst clears all counters. Counters do not change when en=0.
- Not defined: no counter flops are built and hit_cnt0..hit_cnt3 are driven constant 0. Port list is identical in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles, ACTIVE_LOW=0 -> I0..I3=0000, valid=0, all hit_cnt=0.
- Exhaustive decode: en=1, {A,B} = 00, 01, 10, 11, each held for 1 cycle -> on the following edges {I3,I2,I1,I0} = 0001, 0010, 0100, 1000, valid=1, 1-cycle latency each.
- Enable hold: decode 10, then en=0 while driving 01 for 3 cycles -> outputs stay 0100. Then en=1 -> 0010 on the next edge.
- Active-low build (ACTIVE_LOW=1): reset -> 1111. {A,B}=11 -> {I3..I0}=0111. valid=1.
- Reset priority: en=1, {A,B}=11, rst=1 on the same edge -> outputs all deasserted, valid=0.
- DEC_HIT_CNT_EN with CNT_W=2: decode 00 five times -> hit_cnt0=3 (saturated), others 0. Without the macro -> all hit_cnt=0.
